// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with a valid/ready handshake on both sides.
// S1 captures operands and command, S2 holds the computed result and flags.
// A sticky overflow flag and a wrapping count of delivered results are also kept.
// Command encoding matches the legacy single-cycle ALU.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       command,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             sticky_ovf,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] CMD_ADD  = 3'b000;
  localparam logic [2:0] CMD_SUB  = 3'b001;
  localparam logic [2:0] CMD_XOR  = 3'b010;
  localparam logic [2:0] CMD_SLT  = 3'b011;
  localparam logic [2:0] CMD_AND  = 3'b100;
  localparam logic [2:0] CMD_NAND = 3'b101;
  localparam logic [2:0] CMD_NOR  = 3'b110;
  localparam logic [2:0] CMD_OR   = 3'b111;

  localparam int MSB = WIDTH - 1;

  // Result bundle produced by the combinational ALU core
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
  } alu_out_t;

  // Combinational ALU core; SUB and SLT share one a + ~b + 1 adder
  function automatic alu_out_t alu_eval(
    input logic [WIDTH-1:0] op_a,
    input logic [WIDTH-1:0] op_b,
    input logic [2:0]       cmd
  );
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           add_ovf;
    logic           sub_ovf;
    alu_out_t       o;
    sum     = {1'b0, op_a} + {1'b0, op_b};
    diff    = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
    sub_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
    o.res   = {WIDTH{1'b0}};
    o.cout  = 1'b0;
    o.ovf   = 1'b0;
    case (cmd)
      CMD_ADD: begin
        o.res  = sum[MSB:0];
        o.cout = sum[WIDTH];
        o.ovf  = add_ovf;
      end
      CMD_SUB: begin
        o.res  = diff[MSB:0];
        o.cout = diff[WIDTH];
        o.ovf  = sub_ovf;
      end
      CMD_XOR:  o.res = op_a ^ op_b;
      // Signed less-than: sign of the difference corrected by its overflow
      CMD_SLT:  o.res = {{(WIDTH-1){1'b0}}, diff[MSB] ^ sub_ovf};
      CMD_AND:  o.res = op_a & op_b;
      CMD_NAND: o.res = ~(op_a & op_b);
      CMD_NOR:  o.res = ~(op_a | op_b);
      CMD_OR:   o.res = op_a | op_b;
      default:  o.res = {WIDTH{1'b0}};
    endcase
    return o;
  endfunction

  // Stage 1 registers
  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [2:0]       s1_cmd_r;

  // Stage 2 registers (drive the outputs directly)
  logic             s2_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             carryout_r;
  logic             overflow_r;
  logic             zero_r;

  logic             sticky_ovf_r;
  logic [CNT_W-1:0] op_count_r;

  // Handshake qualifiers
  logic             s1_leaving_s;
  logic             s2_leaving_s;
  logic             in_ready_s;
  logic             accept_s;
  alu_out_t         alu_s;

  // Transfer qualifiers: a stage may load when empty or when draining this cycle
  always_comb begin
    s2_leaving_s = s2_valid_r & out_ready;
    s1_leaving_s = s1_valid_r & (~s2_valid_r | out_ready);
    in_ready_s   = ~s1_valid_r | s1_leaving_s;
    accept_s     = in_valid & in_ready_s;
  end

  // Evaluate the ALU on the contents of stage 1
  always_comb begin
    alu_s = alu_eval(s1_a_r, s1_b_r, s1_cmd_r);
  end

  // Stage 1: capture operands and command on an accepted input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_cmd_r   <= 3'b000;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= a;
      s1_b_r     <= b;
      s1_cmd_r   <= command;
    end else if (s1_leaving_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: register result and flags when stage 1 hands over; hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      result_r   <= {WIDTH{1'b0}};
      carryout_r <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b1;
    end else if (s1_leaving_s) begin
      s2_valid_r <= 1'b1;
      result_r   <= alu_s.res;
      carryout_r <= alu_s.cout;
      overflow_r <= alu_s.ovf;
      zero_r     <= (alu_s.res == {WIDTH{1'b0}});
    end else if (s2_leaving_s) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // Sticky overflow: an overflowing delivery takes priority over a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf_r <= 1'b0;
    end else if (s2_leaving_s && overflow_r) begin
      sticky_ovf_r <= 1'b1;
    end else if (sticky_clr) begin
      sticky_ovf_r <= 1'b0;
    end else begin
      sticky_ovf_r <= sticky_ovf_r;
    end
  end

  // Delivered-result counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= {CNT_W{1'b0}};
    end else if (s2_leaving_s) begin
      op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      op_count_r <= op_count_r;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = s2_valid_r;
  assign result     = result_r;
  assign carryout   = carryout_r;
  assign overflow   = overflow_r;
  assign zero       = zero_r;
  assign sticky_ovf = sticky_ovf_r;
  assign op_count   = op_count_r;

endmodule
